// File: rtl/norm_apply_unit_pkg.sv
// Shared types and helpers for the normalisation apply unit: FSM state
// encoding, default geometry and the output saturation helper.
package norm_apply_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int DEF_D    = 4;
    localparam int DEF_DW   = 8;
    localparam int DEF_RS_W = 8;
    localparam int DEF_GF   = 6;

    // Clamp a wide signed value into the range of a dw-bit signed number.
    function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] v,
                                                     input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/norm_apply_unit_if.sv
// Operand/result bundle for norm_apply_unit. The unit sits on the slave side;
// whoever supplies vectors and consumes elements uses the master side.
interface norm_apply_unit_if
    import norm_apply_unit_pkg::*;
#(
    parameter int D      = DEF_D,
    parameter int DW     = DEF_DW,
    parameter int ACC1_W = DW + $clog2(D),
    parameter int RS_W   = DEF_RS_W
);
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;

    logic                     start;
    logic [D-1:0][DW-1:0]     x;
    logic signed [ACC1_W-1:0] mean;
    logic [RS_W-1:0]          rsqrt;
    logic [D-1:0][DW-1:0]     gamma;
    logic [D-1:0][DW-1:0]     beta;
    logic                     out_ready;

    logic signed [DW-1:0]     y;
    logic [IDX_W-1:0]         y_idx;
    logic                     out_valid;
    logic                     y_last;
    logic                     busy;
    logic                     done;

    modport master (
        output start, x, mean, rsqrt, gamma, beta, out_ready,
        input  y, y_idx, out_valid, y_last, busy, done
    );

    modport slave (
        input  start, x, mean, rsqrt, gamma, beta, out_ready,
        output y, y_idx, out_valid, y_last, busy, done
    );

endinterface

// File: rtl/norm_apply_unit_dp.sv
// Combinational per-element datapath: scale a centred value by rsqrt and
// gamma with round-half-up shifts, add beta and saturate to DW bits.
module norm_apply_dp
    import norm_apply_unit_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int ACC1_W = DW + $clog2(DEF_D),
    parameter int RS_W   = DEF_RS_W,
    parameter int GF     = DEF_GF
) (
    input  logic signed [ACC1_W:0]  d_i,
    input  logic        [RS_W-1:0]  rsqrt_i,
    input  logic signed [DW-1:0]    gamma_i,
    input  logic signed [DW-1:0]    beta_i,
    output logic signed [DW-1:0]    y_o
);
    // Widths leave headroom for the product plus the rounding constant.
    localparam int DIFF_W  = ACC1_W + 1;
    localparam int PROD1_W = DIFF_W + RS_W + 2;
    localparam int PROD2_W = PROD1_W + DW + 1;
    localparam int SUM_W   = PROD2_W + 1;

    localparam logic signed [PROD1_W-1:0] RND1 = PROD1_W'(64'sd1 <<< (RS_W - 1));
    localparam logic signed [PROD2_W-1:0] RND2 = PROD2_W'(64'sd1 <<< (GF - 1));

    logic signed [PROD1_W-1:0] d_ext;
    logic signed [PROD1_W-1:0] r_ext;
    logic signed [PROD1_W-1:0] prod1;
    logic signed [PROD1_W-1:0] p;
    logic signed [PROD2_W-1:0] p_ext;
    logic signed [PROD2_W-1:0] g_ext;
    logic signed [PROD2_W-1:0] prod2;
    logic signed [PROD2_W-1:0] q;
    logic signed [SUM_W-1:0]   s;

    assign d_ext = PROD1_W'(d_i);
    assign r_ext = PROD1_W'({1'b0, rsqrt_i});
    assign prod1 = d_ext * r_ext + RND1;
    assign p     = prod1 >>> RS_W;

    assign p_ext = PROD2_W'(p);
    assign g_ext = PROD2_W'(gamma_i);
    assign prod2 = p_ext * g_ext + RND2;
    assign q     = prod2 >>> GF;

    assign s   = SUM_W'(q) + SUM_W'(beta_i);
    assign y_o = DW'(sat_to_dw(64'(s), DW));

endmodule

// File: rtl/norm_apply_unit.sv
// Captures one vector with its statistics and affine parameters, then streams
// the normalised elements out one per handshake, in index order.
module norm_apply_unit
    import norm_apply_unit_pkg::*;
#(
    parameter int D      = DEF_D,
    parameter int DW     = DEF_DW,
    parameter int ACC1_W = DW + $clog2(D),
    parameter int RS_W   = DEF_RS_W,
    parameter int GF     = DEF_GF
) (
    input  logic            clk,
    input  logic            rst,
    norm_apply_unit_if.slave bus
);
    localparam int IDX_W  = (D > 1) ? $clog2(D) : 1;
    localparam int DIFF_W = ACC1_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

    state_e state_q, state_d;

    logic [DW-1:0]            x_q     [D];
    logic [DW-1:0]            gamma_q [D];
    logic [DW-1:0]            beta_q  [D];
    logic signed [ACC1_W-1:0] mean_q;
    logic [RS_W-1:0]          rsqrt_q;
    logic [IDX_W-1:0]         load_idx_q;

    logic signed [DW-1:0]     y_q;
    logic [IDX_W-1:0]         y_idx_q;
    logic                     out_valid_q;
    logic                     y_last_q;
    logic                     done_q;

    logic                     handshake;
    logic                     capture;
    logic                     load_en;
    logic                     last_hs;
    logic signed [DIFF_W-1:0] diff;
    logic signed [DW-1:0]     dp_y;

    assign handshake = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RUN keeps loading while the output register is empty or being drained.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        load_en = 1'b0;
        last_hs = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!out_valid_q || handshake) begin
                    load_en = 1'b1;
                    if (load_idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (handshake) begin
                    last_hs = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.y         = y_q;
        bus.y_idx     = y_idx_q;
        bus.out_valid = out_valid_q;
        bus.y_last    = y_last_q;
        bus.done      = done_q;
    end

    assign diff = DIFF_W'($signed(x_q[load_idx_q])) - DIFF_W'(mean_q);

    norm_apply_dp #(
        .DW     (DW),
        .ACC1_W (ACC1_W),
        .RS_W   (RS_W),
        .GF     (GF)
    ) u_dp (
        .d_i     (diff),
        .rsqrt_i (rsqrt_q),
        .gamma_i (gamma_q[load_idx_q]),
        .beta_i  (beta_q[load_idx_q]),
        .y_o     (dp_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                x_q[i]     <= '0;
                gamma_q[i] <= '0;
                beta_q[i]  <= '0;
            end
            mean_q      <= '0;
            rsqrt_q     <= '0;
            load_idx_q  <= '0;
            y_q         <= '0;
            y_idx_q     <= '0;
            out_valid_q <= 1'b0;
            y_last_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= last_hs;
            if (capture) begin
                for (int i = 0; i < D; i++) begin
                    x_q[i]     <= bus.x[i];
                    gamma_q[i] <= bus.gamma[i];
                    beta_q[i]  <= bus.beta[i];
                end
                mean_q     <= bus.mean;
                rsqrt_q    <= bus.rsqrt;
                load_idx_q <= '0;
            end
            if (load_en) begin
                y_q         <= dp_y;
                y_idx_q     <= load_idx_q;
                y_last_q    <= (load_idx_q == LAST_IDX);
                out_valid_q <= 1'b1;
                load_idx_q  <= load_idx_q + IDX_W'(1);
            end else if (last_hs) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/norm_apply_unit.md
NORM_APPLY_UNIT -- requirements
Module: norm_apply_unit

Interface
REQ-001 Parameter D, default 4: vector length.
REQ-002 Parameter DW, default 8: input/output element width, signed.
REQ-003 Parameter ACC1_W, default DW+$clog2(D): mean width, signed.
REQ-004 Parameter RS_W, default 8: rsqrt width, unsigned Q0.RS_W.
REQ-005 Parameter GF, default 6: gamma fraction bits; gamma is signed DW bits, Q(DW-1-GF).GF.
REQ-006 clk  in  1  sole clock; all logic on posedge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse; capture all operands.
REQ-009 x  in  D x DW signed  input vector.
REQ-010 mean  in  ACC1_W signed  vector mean.
REQ-011 rsqrt  in  RS_W  1/sqrt(var+eps), Q0.RS_W.
REQ-012 gamma  in  D x DW signed  per-element scale.
REQ-013 beta  in  D x DW signed  per-element offset.
REQ-014 y  out  DW signed  normalized element.
REQ-015 y_idx  out  $clog2(D) (min 1)  index of element on y.
REQ-016 out_valid  out  1  y/y_idx/y_last valid.
REQ-017 out_ready  in  1  consumer accepts when out_valid&&out_ready.
REQ-018 y_last  out  1  high with element D-1.
REQ-019 busy  out  1  high from capture until final handshake.
REQ-020 done  out  1  one-cycle pulse the cycle after final handshake.

Function
REQ-021 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when element D-1 loaded into y; DRAIN->IDLE on its handshake.
REQ-022 At the edge where start is sampled in IDLE, x, mean, rsqrt, gamma, beta are registered; later input changes have no effect on the current vector.
REQ-023 start in RUN or DRAIN is ignored.
REQ-024 Element i: d = x[i]-mean at ACC1_W+1 bits; p = (d*rsqrt + 2^(RS_W-1)) >>> RS_W; q = (p*gamma[i] + 2^(GF-1)) >>> GF; s = q + beta[i]; all intermediates full-precision, no overflow.
REQ-025 y = s saturated to [-2^(DW-1), 2^(DW-1)-1]; shifts arithmetic (round half up).
REQ-026 Element 0 loads into y at the edge after capture; out_valid first high two cycles after the start cycle.
REQ-027 y, y_idx, y_last hold stable while out_valid && !out_ready.
REQ-028 On handshake, element i+1 loads at that edge; out_valid stays high; one element per cycle at full throughput.
REQ-029 On handshake of element D-1, out_valid and busy drop at that edge; done pulses in the following cycle.
REQ-030 Elements emitted strictly in order 0..D-1, each exactly once.
REQ-031 rsqrt = 0 yields y[i] = beta[i].
REQ-032 start sampled in the done cycle begins a new capture normally.

Reset
REQ-033 rst forces IDLE; y=0, y_idx=0, out_valid=0, y_last=0, busy=0, done=0; captured registers cleared.
REQ-034 rst mid-operation aborts the vector; no further output or done pulse; rst overrides simultaneous start.

Structure
REQ-035 Shared package holds FSM state enum, default D/DW/RS_W/GF constants, and a saturate-to-DW function.
REQ-036 One sub-module norm_apply_dp: combinational datapath for REQ-024/025 (d, rsqrt, gamma, beta in; y out); FSM, capture, and handshake in the top.

Verification
REQ-037 D=4, x={10,20,30,40}, mean=25, rsqrt=0x80, gamma=64 all, beta=0, out_ready=1 -> y=-7,-2,3,8 on consecutive cycles, idx 0..3, y_last on 3, done next cycle.
REQ-038 x[0]=127, mean=-128, rsqrt=0xFF, gamma[0]=127, beta[0]=100 -> y[0]=127 (saturated); x[0]=-128, mean=127, beta[0]=-100 -> y[0]=-128.
REQ-039 REQ-037 stimulus with out_ready toggled 1,0,0,1,0,1,1 -> same four values in order, each held stable while stalled, no drop or duplicate.
REQ-040 Second start with different x issued during RUN -> ignored; outputs match first vector.
REQ-041 rst asserted after element 1 handshake -> next cycle all outputs zero, no done; fresh start then produces correct full vector.
REQ-042 rsqrt=0, beta={5,-3,0,127} -> y=5,-3,0,127.
